// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the memory port
// arbiter and the single-port unified memory.
// slave  : arbiter view (takes requests and memory read data)
// master : requester/memory view (drives requests and memory read data)
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    localparam int unsigned BW = DW / 8;

    // fetch port
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_stall;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    // load/store port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_be;
    logic          d_gnt;
    logic          d_stall;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    // memory port
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [BW-1:0] m_be;
    logic [DW-1:0] m_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  m_rdata,
        output if_gnt, if_stall, if_rvalid, if_rdata,
        output d_gnt, d_stall, d_rvalid, d_rdata,
        output m_en, m_we, m_addr, m_wdata, m_be
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output m_rdata,
        input  if_gnt, if_stall, if_rvalid, if_rdata,
        input  d_gnt, d_stall, d_rvalid, d_rdata,
        input  m_en, m_we, m_addr, m_wdata, m_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port unified I/D memory between the fetch
// stage and the load/store stage. The data port wins by default; a
// starvation counter forces one fetch grant after STARVE_MAX denials.
// Optional macro ARB_PERF_CNT_EN adds stall / forced-grant counters.
module mem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]          perf_if_stall,
    output logic [31:0]          perf_d_stall,
    output logic [31:0]          perf_forced
`endif
);
    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D_RD = 2'd2,
        OWN_D_WR = 2'd3
    } own_e;

    own_e          own_q, own_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          if_win;
    logic          d_win;

    // Byte-offset bits never reach the word-aligned memory address.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.d_addr[1:0]};

    // Owner of the in-flight response and the fetch starvation count.
    always_ff @(posedge clk) begin
        if (reset) begin
            own_q    <= OWN_NONE;
            starve_q <= '0;
        end else begin
            own_q    <= own_d;
            starve_q <= starve_d;
        end
    end

    // Grant decision, memory mux, next owner, starvation count and responses.
    always_comb begin
        if_win       = 1'b0;
        d_win        = 1'b0;
        own_d        = OWN_NONE;
        starve_d     = '0;
        bus.m_en     = 1'b0;
        bus.m_we     = 1'b0;
        bus.m_addr   = '0;
        bus.m_wdata  = '0;
        bus.m_be     = '0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = '0;

        if (!reset) begin
            if_win = bus.if_req && (!bus.d_req || (starve_q == STARVE_LIM));
            d_win  = bus.d_req && !if_win;
        end

        if (if_win) begin
            bus.m_en   = 1'b1;
            bus.m_addr = {bus.if_addr[AW-1:2], 2'b00};
            bus.m_be   = {BW{1'b1}};
            own_d      = OWN_IF;
        end else if (d_win) begin
            bus.m_en    = 1'b1;
            bus.m_we    = bus.d_we;
            bus.m_addr  = {bus.d_addr[AW-1:2], 2'b00};
            bus.m_wdata = bus.d_wdata;
            bus.m_be    = bus.d_we ? bus.d_be : {BW{1'b1}};
            own_d       = bus.d_we ? OWN_D_WR : OWN_D_RD;
        end

        if (bus.if_req && !if_win) begin
            starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + CW'(1);
        end

        if (!reset) begin
            case (own_q)
                OWN_IF: begin
                    bus.if_rvalid = 1'b1;
                    bus.if_rdata  = bus.m_rdata;
                end
                OWN_D_RD: begin
                    bus.d_rvalid = 1'b1;
                    bus.d_rdata  = bus.m_rdata;
                end
                OWN_D_WR: begin
                    bus.d_rvalid = 1'b1;
                end
                default: begin
                    bus.if_rvalid = 1'b0;
                end
            endcase
        end

        bus.if_gnt   = if_win;
        bus.d_gnt    = d_win;
        bus.if_stall = !reset && bus.if_req && !if_win;
        bus.d_stall  = !reset && bus.d_req && !d_win;
    end

`ifdef ARB_PERF_CNT_EN
    // Wrapping event counters: stall cycles per port and starvation wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_stall <= '0;
            perf_d_stall  <= '0;
            perf_forced   <= '0;
        end else begin
            if (bus.if_stall) perf_if_stall <= perf_if_stall + 32'd1;
            if (bus.d_stall)  perf_d_stall  <= perf_d_stall + 32'd1;
            if (if_win && bus.d_req) perf_forced <= perf_forced + 32'd1;
        end
    end
`endif
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the riscvpipeline fetch stage and its load/store stage.
- Fixed-priority arbitration: the data port wins by default.
- A starvation counter guarantees that instruction fetch still makes progress.
- Generates per-requester grants, stalls and response-valid strobes. The pipeline uses the stalls to freeze IF or MEM.

Parameters:
- AW, 32, address width in bits (byte address).
- DW, 32, data width in bits.
- STARVE_MAX, 4, number of consecutive denied fetch cycles before fetch is forced to win one grant (range 1..15).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  AW  fetch byte address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_stall  out  1  if_req & ~if_gnt
- if_rvalid  out  1  fetch read data valid (one cycle after if_gnt)
- if_rdata  out  DW  fetch read data
- d_req  in  1  data request; held with its fields until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data byte address
- d_wdata  in  DW  store data
- d_be  in  DW/8  store byte enables
- d_gnt  out  1  data accepted this cycle (combinational)
- d_stall  out  1  d_req & ~d_gnt
- d_rvalid  out  1  load data valid, or store acknowledged (one cycle after d_gnt)
- d_rdata  out  DW  load data; 0 on a store ack
- m_en  out  1  memory access this cycle
- m_we  out  1  memory write
- m_addr  out  AW  memory byte address; bits [1:0] forced to 0
- m_wdata  out  DW  memory write data
- m_be  out  DW/8  memory byte enables; all ones on reads
- m_rdata  in  DW  memory read data, valid the cycle after m_en

Behaviour:
- Memory model: synchronous, one access per cycle, read latency exactly 1. Back-to-back grants are allowed every cycle.
- Grant rule (combinational, from registered state):
  - Only one requester active: it is granted.
  - Both active and starve_cnt < STARVE_MAX: d_gnt = 1.
  - Both active and starve_cnt == STARVE_MAX: if_gnt = 1.
  - if_gnt and d_gnt are never both 1.
- Memory drive:
  - m_en = if_gnt | d_gnt.
  - m_we = d_gnt & d_we.
  - The muxed address, data and byte enables come from the winner.
  - With no winner, m_addr, m_wdata and m_be are driven to 0.
- starve_cnt (4-bit register):
  - Increments when if_req & ~if_gnt.
  - Clears on if_gnt or when if_req is low.
  - Saturates at STARVE_MAX.
- Response tracking: the owner register resp_own is one of {NONE, IF, D_RD, D_WR}. It is loaded each cycle with the current grant type (NONE if no grant).
- Outputs by resp_own:
  - IF: if_rvalid = 1 and if_rdata = m_rdata.
  - D_RD: d_rvalid = 1 and d_rdata = m_rdata.
  - D_WR: d_rvalid = 1 and d_rdata = 0.
  - Otherwise: both rvalid = 0 and both rdata = 0.
- Requester stability: a requester must keep req and its fields stable while stalled. Dropping req before its grant is legal and withdraws the request without any response.
- Reset:
  - resp_own = NONE and starve_cnt = 0.
  - if_rvalid, d_rvalid, if_rdata and d_rdata are all 0.
  - Grants are still computed combinationally from the inputs. While reset is high, grants, m_en and both stalls are forced to 0.
  - A response in flight when reset is asserted is dropped; no rvalid appears after reset.
- A read and a write to the same address in consecutive cycles are granted in order. A load granted the cycle after a store returns the new data, given memory write-then-read ordering.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: adds three 32-bit output ports, each a wrapping counter cleared by reset.
  - perf_if_stall: cycles with if_stall = 1.
  - perf_d_stall: cycles with d_stall = 1.
  - perf_forced: cycles in which fetch won through starvation.
- Not defined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Fetch only: if_req held with addresses 0x0, 0x4, 0x8 -> if_gnt on every cycle, if_rvalid one cycle after each grant, data matches the memory contents, d_rvalid stays 0.
- Conflict: if_req and d_req (load 0x64) in the same cycle -> d_gnt = 1, if_stall = 1; the next cycle if_gnt = 1 (once d_req is dropped); d_rvalid and if_rvalid appear in consecutive cycles.
- Starvation: if_req held with d_req held for 10 cycles, STARVE_MAX = 4 -> d_gnt for 4 cycles, then if_gnt for 1 cycle; the pattern repeats and starve_cnt never exceeds 4.
- Store then load: store 25 to 0x64 with d_be = 0xF, then load 0x64 -> m_we = 1 in cycle N, d_rvalid with d_rdata = 0 in N+1, and the load returns 25.
- Reset mid-flight: assert reset in the cycle after a fetch grant -> no if_rvalid, all outputs 0, starve_cnt = 0; a normal grant resumes after release.
- ARB_PERF_CNT_EN: repeat the starvation test for 10 cycles -> perf_forced = 2, perf_d_stall = 2, perf_if_stall = 8.
